// File: rtl/uart_line_editor.sv
`default_nettype none
// ============================================================================
// Module  : uart_line_editor
// Brief   : Collects a received text line with backspace editing, then
//           replays it (optionally followed by CR LF) to the UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
module uart_line_editor #(
    parameter int LINE_MAX    = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int APPEND_CRLF = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            rx_data,
    input  logic                             rx_valid,
    input  logic                             tx_busy,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_trigger,
    output logic [$clog2(LINE_MAX+1)-1:0]    line_len,
    output logic                             sending,
    output logic                             rx_drop
);

    localparam int c_LEN_W = $clog2(LINE_MAX + 1);
    localparam int c_IDX_W = $clog2(LINE_MAX + 3);

    localparam logic [DATA_WIDTH-1:0] c_CR  = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] c_LF  = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] c_BS  = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] c_DEL = DATA_WIDTH'(8'h7F);

    localparam logic [1:0] c_COLLECT   = 2'd0;
    localparam logic [1:0] c_WAIT_IDLE = 2'd1;
    localparam logic [1:0] c_ISSUE     = 2'd2;
    localparam logic [1:0] c_WAIT_ACK  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic [c_IDX_W-1:0]    w_idx_inc;
    logic [c_IDX_W-1:0]    w_total;
    logic [c_LEN_W-1:0]    w_len_nxt;
    logic [DATA_WIDTH-1:0] w_tx_data_nxt;
    logic [DATA_WIDTH-1:0] w_seq_byte;
    logic                  w_drop_nxt;
    logic                  w_wr_en;
    logic                  w_is_term;
    logic                  w_is_bs;
    logic                  w_more;

    // One spare entry keeps the index width equal to the line_len width.
    logic [DATA_WIDTH-1:0] r_buf [0:LINE_MAX];

    assign w_is_term = (rx_data == c_CR) || (rx_data == c_LF);
    assign w_is_bs   = (rx_data == c_BS) || (rx_data == c_DEL);
    assign w_idx_inc = r_idx + c_IDX_W'(1);
    assign w_total   = c_IDX_W'(line_len) + c_IDX_W'((APPEND_CRLF != 0) ? 2 : 0);
    assign w_more    = (w_idx_inc < w_total);

    // Replay sequence: body bytes, then CR, then LF.
    always_comb begin
        w_seq_byte = c_LF;
        if (w_idx_inc < c_IDX_W'(line_len))
            w_seq_byte = r_buf[w_idx_inc[c_LEN_W-1:0]];
        else if (w_idx_inc == c_IDX_W'(line_len))
            w_seq_byte = c_CR;
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_COLLECT;
            r_idx      <= '0;
            line_len   <= '0;
            tx_data    <= '0;
            tx_trigger <= 1'b0;
            sending    <= 1'b0;
            rx_drop    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            line_len   <= w_len_nxt;
            tx_data    <= w_tx_data_nxt;
            tx_trigger <= (w_state_nxt == c_ISSUE);
            sending    <= (w_state_nxt != c_COLLECT);
            rx_drop    <= w_drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_buf[line_len] <= rx_data;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_COLLECT:
                if (rx_valid && w_is_term && (line_len != '0))
                    w_state_nxt = c_WAIT_IDLE;
            c_WAIT_IDLE:
                if (!tx_busy)
                    w_state_nxt = c_ISSUE;
            c_ISSUE:
                w_state_nxt = c_WAIT_ACK;
            c_WAIT_ACK:
                if (tx_busy)
                    w_state_nxt = w_more ? c_WAIT_IDLE : c_COLLECT;
            default:
                w_state_nxt = c_COLLECT;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        w_len_nxt     = line_len;
        w_idx_nxt     = r_idx;
        w_tx_data_nxt = tx_data;
        w_drop_nxt    = 1'b0;
        w_wr_en       = 1'b0;
        case (r_state)
            c_COLLECT: begin
                if (rx_valid) begin
                    if (w_is_term) begin
                        if (line_len != '0) begin
                            w_idx_nxt     = '0;
                            w_tx_data_nxt = r_buf[0];
                        end
                    end else if (w_is_bs) begin
                        if (line_len != '0)
                            w_len_nxt = line_len - c_LEN_W'(1);
                    end else if (line_len < c_LEN_W'(LINE_MAX)) begin
                        w_wr_en   = 1'b1;
                        w_len_nxt = line_len + c_LEN_W'(1);
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            c_WAIT_ACK: begin
                w_drop_nxt = rx_valid;
                if (tx_busy) begin
                    if (w_more) begin
                        w_idx_nxt     = w_idx_inc;
                        w_tx_data_nxt = w_seq_byte;
                    end else begin
                        w_idx_nxt = '0;
                        w_len_nxt = '0;
                    end
                end
            end
            default:
                w_drop_nxt = rx_valid;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_line_editor.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_line_editor
// Brief   : Directed stimulus with a queue scoreboard for uart_line_editor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_line_editor;

    localparam int c_LINE_MAX = 32;
    localparam int c_LEN_W    = $clog2(c_LINE_MAX + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         rx_data = '0;
    logic               rx_valid = 1'b0;
    logic               tx_busy = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_trigger;
    logic [c_LEN_W-1:0] line_len;
    logic               sending;
    logic               rx_drop;

    logic [7:0] exp_q [$];
    int vectors     = 0;
    int miscompares = 0;
    int trig_count  = 0;
    int drop_count  = 0;
    int busy_cnt    = 0;
    int cyc         = 0;
    int last_trig   = -100;
    logic hold_busy = 1'b0;

    uart_line_editor #(
        .LINE_MAX   (c_LINE_MAX),
        .DATA_WIDTH (8),
        .APPEND_CRLF(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_trigger(tx_trigger),
        .line_len  (line_len),
        .sending   (sending),
        .rx_drop   (rx_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor and transmitter model: busy for 10 cycles after each trigger.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_trigger) begin
            trig_count++;
            check("trigger_while_busy", {31'd0, tx_busy}, 32'd0);
            check("trigger_spacing_ok", {31'd0, (cyc - last_trig) >= 3}, 32'd1);
            last_trig = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_trigger", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = hold_busy || (busy_cnt != 0);
        if (rx_drop) drop_count++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_line(input string s, input bit crlf);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sending || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, n < 3000}, 32'd1);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int t0;
        int d0;
        int n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_line_len", {26'd0, line_len}, 32'd0);
        check("reset_sending", {31'd0, sending}, 32'd0);
        check("reset_trigger", {31'd0, tx_trigger}, 32'd0);
        check("reset_drop", {31'd0, rx_drop}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);

        // "AB\r" with two-cycle trigger latency
        expect_line("AB", 1'b1);
        send_str("AB");
        check("ab_len", {26'd0, line_len}, 32'd2);
        send_byte(8'h0D);
        check("ab_trig_n1", {31'd0, tx_trigger}, 32'd0);
        check("ab_sending", {31'd0, sending}, 32'd1);
        @(negedge clk);
        check("ab_trig_n2", {31'd0, tx_trigger}, 32'd1);
        wait_idle();
        check("ab_len_end", {26'd0, line_len}, 32'd0);
        check("ab_sending_end", {31'd0, sending}, 32'd0);
        check("ab_trigs", trig_count, 32'd4);

        // Backspace editing and backspace on an empty line
        expect_line("ABD", 1'b1);
        send_str("ABC");
        send_byte(8'h08);
        check("bs_len", {26'd0, line_len}, 32'd2);
        send_byte("D");
        send_byte(8'h0A);
        wait_idle();
        d0 = drop_count;
        send_byte(8'h08);
        @(negedge clk);
        check("bs_empty_len", {26'd0, line_len}, 32'd0);
        check("bs_empty_drop", drop_count, d0);

        // Terminators on an empty line are silent
        t0 = trig_count;
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_byte(8'h0D);
        repeat (20) @(negedge clk);
        check("blank_trigs", trig_count, t0);
        check("blank_drops", drop_count, d0);
        check("blank_sending", {31'd0, sending}, 32'd0);

        // Overflow: 34 bytes, two dropped
        t0 = trig_count;
        for (int i = 0; i < c_LINE_MAX; i++) begin
            send_byte(8'h55);
            exp_q.push_back(8'h55);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        check("full_len", {26'd0, line_len}, c_LINE_MAX);
        send_byte(8'h55);
        check("ovf_drop_pulse", {31'd0, rx_drop}, 32'd1);
        send_byte(8'h55);
        @(negedge clk);
        check("ovf_drops", drop_count, d0 + 2);
        check("ovf_len", {26'd0, line_len}, c_LINE_MAX);
        send_byte(8'h0D);
        wait_idle();
        check("ovf_trigs", trig_count, t0 + 34);

        // Byte arriving during replay is dropped
        d0 = drop_count;
        expect_line("XY", 1'b1);
        send_str("XY");
        send_byte(8'h0D);
        repeat (3) @(negedge clk);
        send_byte(8'h31);
        check("replay_drop_pulse", {31'd0, rx_drop}, 32'd1);
        wait_idle();
        check("replay_drops", drop_count, d0 + 1);

        // Transmitter busy at the terminator holds off the trigger
        hold_busy = 1'b1;
        @(negedge clk);
        t0 = trig_count;
        expect_line("Q", 1'b1);
        send_byte("Q");
        send_byte(8'h0D);
        repeat (10) @(negedge clk);
        check("hold_no_trig", trig_count, t0);
        hold_busy = 1'b0;
        @(posedge clk);
        #2;
        check("hold_trig_1", trig_count, t0);
        @(posedge clk);
        #2;
        check("hold_trig_2", trig_count, t0 + 1);
        wait_idle();

        // Reset mid-replay aborts the line
        t0 = trig_count;
        exp_q.push_back("H");
        exp_q.push_back("E");
        send_str("HELLO");
        send_byte(8'h0D);
        n = 0;
        while (trig_count < t0 + 2 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("hello_two_trigs", {31'd0, n < 500}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_trigger", {31'd0, tx_trigger}, 32'd0);
        check("abort_sending", {31'd0, sending}, 32'd0);
        check("abort_len", {26'd0, line_len}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_trigs", trig_count, t0 + 2);
        expect_line("Z", 1'b1);
        send_byte("Z");
        send_byte(8'h0D);
        wait_idle();
        check("z_trigs", trig_count, t0 + 5);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
